// File: rtl/sram_loader_if.sv
// Host byte link and Wishbone write port of the SRAM loader.
// The master modport is the loader side; the slave modport is the host/SRAM side.
interface sram_loader_if #(
    parameter int ADDR_W = 18
) ();
    logic [7:0]        rx_dat_i;
    logic              rx_valid_i;
    logic              rx_ready_o;
    logic              sram_wb_cyc_o;
    logic              sram_wb_stb_o;
    logic              sram_wb_we_o;
    logic [ADDR_W-1:0] sram_wb_adr_o;
    logic [15:0]       sram_wb_dat_o;
    logic              sram_wb_ack_i;

    modport master (
        input  rx_dat_i, rx_valid_i, sram_wb_ack_i,
        output rx_ready_o, sram_wb_cyc_o, sram_wb_stb_o, sram_wb_we_o,
        output sram_wb_adr_o, sram_wb_dat_o
    );

    modport slave (
        output rx_dat_i, rx_valid_i, sram_wb_ack_i,
        input  rx_ready_o, sram_wb_cyc_o, sram_wb_stb_o, sram_wb_we_o,
        input  sram_wb_adr_o, sram_wb_dat_o
    );
endinterface

// File: rtl/sram_loader.sv
// Host byte-stream loader: decodes SET_ADDR / WRITE commands and issues
// single 16-bit Wishbone writes into the waveform SRAM with address auto-increment.
module sram_loader #(
    parameter int         ADDR_W      = 18,
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [7:0] OP_SETADDR  = 8'hA1,
    parameter logic [7:0] OP_WRITE    = 8'hA2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    sram_loader_if.master     bus,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);
    // Timer value at which the last unacknowledged WB cycle is abandoned.
    localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_A0, S_A1, S_A2, S_C0, S_C1, S_DL, S_DH, S_WB
    } state_t;

    state_t            state;
    logic [15:0]       count;
    logic [15:0]       to_cnt;
    logic [7:0]        lo_byte;
    logic              rx_ready;
    logic              cyc;
    logic [ADDR_W-1:0] adr;
    logic [15:0]       dat;
    logic              take;

    assign take              = bus.rx_valid_i && rx_ready;
    assign bus.rx_ready_o    = rx_ready;
    assign bus.sram_wb_cyc_o = cyc;
    assign bus.sram_wb_stb_o = cyc;
    assign bus.sram_wb_we_o  = cyc;
    assign bus.sram_wb_adr_o = adr;
    assign bus.sram_wb_dat_o = dat;
    assign busy_o            = (state != S_IDLE);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state    <= S_IDLE;
            addr_o   <= '0;
            count    <= '0;
            to_cnt   <= '0;
            lo_byte  <= '0;
            rx_ready <= 1'b1;
            cyc      <= 1'b0;
            adr      <= '0;
            dat      <= '0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (state)
                S_IDLE: if (take) begin
                    if (bus.rx_dat_i == OP_SETADDR)    state <= S_A0;
                    else if (bus.rx_dat_i == OP_WRITE) state <= S_C0;
                    else                               err_o <= 1'b1;
                end
                S_A0: if (take) begin
                    addr_o[7:0] <= bus.rx_dat_i;
                    state       <= S_A1;
                end
                S_A1: if (take) begin
                    addr_o[15:8] <= bus.rx_dat_i;
                    state        <= S_A2;
                end
                // Only the low ADDR_W-16 bits of the top address byte are meaningful.
                S_A2: if (take) begin
                    addr_o[ADDR_W-1:16] <= bus.rx_dat_i[ADDR_W-17:0];
                    state               <= S_IDLE;
                end
                S_C0: if (take) begin
                    count[7:0] <= bus.rx_dat_i;
                    state      <= S_C1;
                end
                S_C1: if (take) begin
                    count[15:8] <= bus.rx_dat_i;
                    if ({bus.rx_dat_i, count[7:0]} == 16'h0000) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end else begin
                        state <= S_DL;
                    end
                end
                S_DL: if (take) begin
                    lo_byte <= bus.rx_dat_i;
                    state   <= S_DH;
                end
                S_DH: if (take) begin
                    dat      <= {bus.rx_dat_i, lo_byte};
                    adr      <= addr_o;
                    cyc      <= 1'b1;
                    rx_ready <= 1'b0;
                    to_cnt   <= '0;
                    state    <= S_WB;
                end
                // Ack wins over timeout when both land on the same edge.
                S_WB: begin
                    if (bus.sram_wb_ack_i) begin
                        cyc      <= 1'b0;
                        rx_ready <= 1'b1;
                        addr_o   <= addr_o + ADDR_W'(1);
                        count    <= count - 16'd1;
                        if (count == 16'd1) begin
                            done_o <= 1'b1;
                            state  <= S_IDLE;
                        end else begin
                            state <= S_DL;
                        end
                    end else if (to_cnt == TO_LAST) begin
                        cyc      <= 1'b0;
                        rx_ready <= 1'b1;
                        err_o    <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 16'd1;
                    end
                end
                default: begin
                    cyc      <= 1'b0;
                    rx_ready <= 1'b1;
                    state    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/sram_loader.md
Name: sram_loader

Overview:
- Host-side loader that fills the waveform SRAM before playback; sits directly upstream of the sram Wishbone slave.
- Consumes a byte stream from the host link (valid/ready), decodes SET_ADDR and WRITE commands, assembles little-endian 16-bit words and issues single Wishbone write cycles with address auto-increment.
- The serial playback engine later reads what this block writes.

Parameters:
- ADDR_W, 18, SRAM word-address width.
- ACK_TIMEOUT, 255, max cycles to wait for sram_wb_ack_i before aborting (must be 1..65535).
- OP_SETADDR, 8'hA1, SET_ADDR opcode.
- OP_WRITE, 8'hA2, WRITE opcode.

Ports:
- wb_clk_i  in  1  single system clock; all logic on its rising edge.
- wb_rst_i  in  1  synchronous, active-low reset.
- rx_dat_i  in  8  host byte.
- rx_valid_i  in  1  rx_dat_i valid.
- rx_ready_o  out  1  loader can accept a byte this cycle.
- sram_wb_cyc_o  out  1  Wishbone cycle.
- sram_wb_stb_o  out  1  Wishbone strobe.
- sram_wb_we_o  out  1  Wishbone write enable (always 1 when stb is high).
- sram_wb_adr_o  out  ADDR_W  write address.
- sram_wb_dat_o  out  16  write data.
- sram_wb_ack_i  in  1  slave acknowledge.
- addr_o  out  ADDR_W  current address pointer.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when a WRITE command completes.
- err_o  out  1  one-cycle pulse on a bad opcode or ack timeout.

Behaviour:
- Reset (wb_rst_i low at a clock edge): state IDLE; all outputs 0 except rx_ready_o=1; addr_o=0; word, count and timeout registers cleared. Reset takes effect mid-command, including during an open Wishbone cycle: cyc and stb drop on the next edge and nothing is retried.
- Byte transfer occurs when rx_valid_i && rx_ready_o at a rising edge. rx_ready_o=1 in every state except WB, where it is 0.
- States:
  - IDLE: accepted byte == OP_SETADDR -> A0. == OP_WRITE -> C0. Any other value -> err_o pulse, byte dropped, stay IDLE.
  - A0 / A1 / A2: load addr[7:0], addr[15:8], addr[17:16] (byte bits 7:2 ignored). addr_o updates on each byte. A2 -> IDLE.
  - C0 / C1: count[7:0], count[15:8]. In C1, a count of 0 -> done_o pulse next cycle, IDLE; otherwise -> DL.
  - DL: latch low data byte -> DH.
  - DH: latch high byte; next cycle enter WB with cyc=stb=we=1, adr=addr_o, dat={hi,lo}.
- WB:
  - cyc, stb, adr and dat are held stable until ack is sampled high.
  - On the ack edge: cyc/stb/we drop the following cycle; addr_o increments modulo 2^ADDR_W (18'h3FFFF wraps to 0); count decrements.
  - count reaches 0 -> done_o pulse coincident with return to IDLE. Otherwise -> DL.
  - Minimum spacing between consecutive writes is 3 cycles after ack (DL, DH, WB entry), given back-to-back bytes.
- Timeout: a counter clears on WB entry and increments each cycle without ack. On reaching ACK_TIMEOUT: drop cyc/stb, err_o pulse, IDLE. addr_o is not incremented; remaining data bytes from the host are then parsed as opcodes.
- An ack sampled outside WB is ignored.
- Bytes arriving while rx_ready_o=0 stay pending on the host side; none are lost.
- done_o and err_o are never high in the same cycle.

Test Plan:
- SET_ADDR: bytes A1,34,12,03 -> addr_o=18'h31234, no Wishbone activity, busy_o low after the last byte.
- WRITE 2 words, ack on the first stb cycle: A1,00,00,00, A2,02,00, FF,FF, 00,00 -> writes (0,16'hFFFF) then (1,16'h0000); done_o pulses once; addr_o=2.
- Wrap with slow slave (ack 3 cycles after stb): SET_ADDR 3FFFF, WRITE 2 words 16'hBEEF, 16'h1234 -> writes at 18'h3FFFF then 0; adr/dat held stable for all 3 wait cycles; rx_ready_o low throughout WB.
- Edge cases: WRITE with count 0 (A2,00,00) -> done_o pulse, no cyc. Opcode 8'h55 -> err_o pulse, state IDLE.
- Timeout with ACK_TIMEOUT=4 and ack tied low: cyc high exactly 4 cycles, then err_o pulse, IDLE, addr_o unchanged.
- Mid-WB reset: drop wb_rst_i while stb is high -> next edge cyc=stb=0, addr_o=0, rx_ready_o=1; a following valid command executes normally.
